// File: rtl/arc4_engine.sv
// arc4_engine: single-FSM ARC4 decrypter with an internal 256x8 S-array.
//   Reads a length-prefixed ciphertext (ct[0]=L, ct[1..L]) and writes a
//   length-prefixed plaintext (pt[0]=L, pt[1..L]).
// Parameters:
//   KEY_BYTES  key length in bytes (1..32); byte 0 is the most significant
//   DROP_N     keystream bytes discarded before pt byte 1
// Build option:
//   ARC4_DROP_EN  when defined, DROP_N keystream bytes are dropped; when
//                 undefined DROP_N is ignored and the engine is plain ARC4.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   en / rdy / done     start request, idle flag, 1-cycle end-of-run pulse
//   key                 key, captured on the start cycle
//   ct_addr/ct_rddata   ciphertext read port (1-cycle read latency)
//   pt_addr/pt_wrdata/pt_wren  plaintext write port
module arc4_engine #(
    parameter int KEY_BYTES = 3,
    parameter int DROP_N    = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    output logic                   rdy,
    output logic                   done,
    input  logic [8*KEY_BYTES-1:0] key,
    output logic [7:0]             ct_addr,
    input  logic [7:0]             ct_rddata,
    output logic [7:0]             pt_addr,
    output logic [7:0]             pt_wrdata,
    output logic                   pt_wren
);

`ifdef ARC4_DROP_EN
    localparam int unsigned DROP_CNT = DROP_N;
`else
    // Drop count folds to zero; DROP_N stays referenced so both builds
    // share the same parameter list.
    localparam int unsigned DROP_CNT = 0 * DROP_N;
`endif
    localparam logic [15:0] DROP_LAST = 16'(DROP_CNT - 1);
    localparam logic [4:0]  KIDX_LAST = 5'(KEY_BYTES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_INIT, S_KSA, S_LEN_RD, S_LEN_WR, S_DROP, S_PRGA, S_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [2:0]             phase_q, phase_d;
    logic [7:0]             i_q, i_d, j_q, j_d, k_q, k_d, len_q, len_d;
    logic [7:0]             si_q, si_d, sj_q, sj_d;
    logic [4:0]             kidx_q, kidx_d;
    logic [15:0]            dcnt_q, dcnt_d;
    logic [8*KEY_BYTES-1:0] key_q, key_d;

    // S-array: single-port synchronous RAM, read data one cycle after address.
    logic [7:0] s_mem [256];
    logic [7:0] s_addr, s_wdata, s_rd_q;
    logic       s_we;
    logic [7:0] key_byte;

    always_ff @(posedge clk) begin
        if (s_we) s_mem[s_addr] <= s_wdata;
        s_rd_q <= s_mem[s_addr];
    end

    // Key byte selected by a running mod-KEY_BYTES index instead of i % KEY_BYTES.
    always_comb begin
        key_byte = 8'd0;
        for (int n = 0; n < KEY_BYTES; n++)
            if (kidx_q == 5'(n)) key_byte = key_q[8*(KEY_BYTES-1-n) +: 8];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            phase_q <= 3'd0;
            i_q     <= 8'd0;
            j_q     <= 8'd0;
            k_q     <= 8'd0;
            len_q   <= 8'd0;
            si_q    <= 8'd0;
            sj_q    <= 8'd0;
            kidx_q  <= 5'd0;
            dcnt_q  <= 16'd0;
            key_q   <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            i_q     <= i_d;
            j_q     <= j_d;
            k_q     <= k_d;
            len_q   <= len_d;
            si_q    <= si_d;
            sj_q    <= sj_d;
            kidx_q  <= kidx_d;
            dcnt_q  <= dcnt_d;
            key_q   <= key_d;
        end
    end

    always_comb begin
        state_d = state_q;
        phase_d = phase_q + 3'd1;
        i_d     = i_q;
        j_d     = j_q;
        k_d     = k_q;
        len_d   = len_q;
        si_d    = si_q;
        sj_d    = sj_q;
        kidx_d  = kidx_q;
        dcnt_d  = dcnt_q;
        key_d   = key_q;
        s_addr  = i_q;
        s_we    = 1'b0;
        s_wdata = 8'd0;
        case (state_q)
            S_IDLE: begin
                phase_d = 3'd0;
                if (en) begin
                    key_d   = key;
                    i_d     = 8'd0;
                    j_d     = 8'd0;
                    state_d = S_INIT;
                end
            end
            S_INIT: begin
                s_we    = 1'b1;
                s_wdata = i_q;
                i_d     = i_q + 8'd1;
                phase_d = 3'd0;
                if (i_q == 8'd255) begin
                    kidx_d  = 5'd0;
                    j_d     = 8'd0;
                    state_d = S_KSA;
                end
            end
            S_KSA: begin
                case (phase_q)
                    3'd0: s_addr = i_q;
                    3'd1: begin
                        si_d   = s_rd_q;
                        j_d    = j_q + s_rd_q + key_byte;
                        s_addr = j_d;
                    end
                    3'd2: begin
                        sj_d    = s_rd_q;
                        s_we    = 1'b1;
                        s_wdata = s_rd_q;
                    end
                    default: begin
                        s_addr  = j_q;
                        s_we    = 1'b1;
                        s_wdata = si_q;
                        i_d     = i_q + 8'd1;
                        kidx_d  = (kidx_q == KIDX_LAST) ? 5'd0 : kidx_q + 5'd1;
                        phase_d = 3'd0;
                        if (i_q == 8'd255) state_d = S_LEN_RD;
                    end
                endcase
            end
            S_LEN_RD: state_d = S_LEN_WR;
            S_LEN_WR: begin
                len_d   = ct_rddata;
                i_d     = 8'd0;
                j_d     = 8'd0;
                k_d     = 8'd1;
                dcnt_d  = 16'd0;
                phase_d = 3'd0;
                if (DROP_CNT != 0)          state_d = S_DROP;
                else if (ct_rddata == 8'd0) state_d = S_DONE;
                else                        state_d = S_PRGA;
            end
            S_DROP, S_PRGA: begin
                case (phase_q)
                    3'd0: begin
                        i_d    = i_q + 8'd1;
                        s_addr = i_d;
                    end
                    3'd1: begin
                        si_d   = s_rd_q;
                        j_d    = j_q + s_rd_q;
                        s_addr = j_d;
                    end
                    3'd2: begin
                        sj_d    = s_rd_q;
                        s_we    = 1'b1;
                        s_wdata = s_rd_q;
                    end
                    3'd3: begin
                        s_addr  = j_q;
                        s_we    = 1'b1;
                        s_wdata = si_q;
                    end
                    3'd4: begin
                        s_addr = si_q + sj_q;
                        // Dropped bytes end after the pad read; the pad is discarded.
                        if (state_q == S_DROP) begin
                            phase_d = 3'd0;
                            dcnt_d  = dcnt_q + 16'd1;
                            if (dcnt_q == DROP_LAST)
                                state_d = (len_q == 8'd0) ? S_DONE : S_PRGA;
                        end
                    end
                    default: begin
                        phase_d = 3'd0;
                        k_d     = k_q + 8'd1;
                        if (k_q == len_q) state_d = S_DONE;
                    end
                endcase
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs decode directly from state so pt[0] can carry ct_rddata in LEN_WR.
    logic xor_cyc;
    assign xor_cyc   = (state_q == S_PRGA) && (phase_q == 3'd5);
    assign rdy       = (state_q == S_IDLE);
    assign done      = (state_q == S_DONE);
    assign ct_addr   = ((state_q == S_PRGA) && (phase_q >= 3'd2)) ? k_q : 8'd0;
    assign pt_wren   = (state_q == S_LEN_WR) || xor_cyc;
    assign pt_addr   = xor_cyc ? k_q : 8'd0;
    assign pt_wrdata = (state_q == S_LEN_WR) ? ct_rddata :
                       xor_cyc ? (ct_rddata ^ s_rd_q) : 8'd0;

endmodule

// File: tb/tb_arc4_engine.sv
module tb_arc4_engine;

`ifdef ARC4_DROP_EN
    localparam int DROP3 = 256;
`else
    localparam int DROP3 = 0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic        en3, rdy3, done3, pt_we3;
    logic [23:0] key3;
    logic [7:0]  ct_addr3, ct_rd3, pt_addr3, pt_wd3;
    logic        en4, rdy4, done4, pt_we4;
    logic [31:0] key4;
    logic [7:0]  ct_addr4, ct_rd4, pt_addr4, pt_wd4;

    arc4_engine #(.KEY_BYTES(3), .DROP_N(256)) u_dut3 (
        .clk(clk), .rst(rst), .en(en3), .rdy(rdy3), .done(done3), .key(key3),
        .ct_addr(ct_addr3), .ct_rddata(ct_rd3),
        .pt_addr(pt_addr3), .pt_wrdata(pt_wd3), .pt_wren(pt_we3));

    arc4_engine #(.KEY_BYTES(4)) u_dut4 (
        .clk(clk), .rst(rst), .en(en4), .rdy(rdy4), .done(done4), .key(key4),
        .ct_addr(ct_addr4), .ct_rddata(ct_rd4),
        .pt_addr(pt_addr4), .pt_wrdata(pt_wd4), .pt_wren(pt_we4));

    logic [7:0] ctm3 [256];
    logic [7:0] ctm4 [256];
    always @(posedge clk) begin
        ct_rd3 <= ctm3[ct_addr3];
        ct_rd4 <= ctm4[ct_addr4];
    end

    logic [7:0] CT1 [10] = '{8'h09, 8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
    logic [7:0] PT1 [10] = '{8'h09, 8'h50, 8'h6C, 8'h61, 8'h69, 8'h6E, 8'h74, 8'h65, 8'h78, 8'h74};
    logic [7:0] CT2 [6]  = '{8'h05, 8'h10, 8'h21, 8'hBF, 8'h04, 8'h20};
    logic [7:0] PT2 [6]  = '{8'h05, 8'h70, 8'h65, 8'h64, 8'h69, 8'h61};

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard: {pt_addr, pt_wrdata} per expected write, and rdy-low length per run.
    logic [15:0] exp3_q [$];
    logic [15:0] exp4_q [$];
    int          len3_q [$];
    int          len4_q [$];

    // Reference ARC4 (plain software form) pushing expected writes for a unit.
    task automatic model_push(input int unit, input logic [255:0] keyv, input int klen, input int drop);
        logic [7:0] s [256];
        logic [7:0] t, pad, l, c;
        int i, j;
        for (int n = 0; n < 256; n++) s[n] = n[7:0];
        j = 0;
        for (int n = 0; n < 256; n++) begin
            j = (j + int'(s[n]) + int'(keyv[8*(klen-(n%klen))-1 -: 8])) & 255;
            t = s[n]; s[n] = s[j]; s[j] = t;
        end
        l = (unit == 3) ? ctm3[0] : ctm4[0];
        if (unit == 3) begin exp3_q.push_back({8'd0, l}); len3_q.push_back(1283 + 6*int'(l) + 5*drop); end
        else           begin exp4_q.push_back({8'd0, l}); len4_q.push_back(1283 + 6*int'(l) + 5*drop); end
        i = 0; j = 0;
        for (int n = 0; n < drop + int'(l); n++) begin
            i = (i + 1) & 255;
            j = (j + int'(s[i])) & 255;
            t = s[i]; s[i] = s[j]; s[j] = t;
            pad = s[(int'(s[i]) + int'(s[j])) & 255];
            if (n >= drop) begin
                c = (unit == 3) ? ctm3[n-drop+1] : ctm4[n-drop+1];
                if (unit == 3) exp3_q.push_back({8'(n-drop+1), c ^ pad});
                else           exp4_q.push_back({8'(n-drop+1), c ^ pad});
            end
        end
    endtask

    // Per-unit output monitors, sampled on the falling edge.
    int run3 = 0, dn3 = 0, run4 = 0, dn4 = 0;
    bit busy3 = 0, last3 = 0, busy4 = 0, last4 = 0;
    logic [15:0] e3, e4;

    always @(negedge clk) begin
        if (rst) begin
            busy3 = 0; run3 = 0; dn3 = 0; last3 = 0;
        end else begin
            if (pt_we3) begin
                if (exp3_q.size() == 0) chk("pt3_unexpected", 32'(exp3_q.size()), 32'd1);
                else begin
                    e3 = exp3_q.pop_front();
                    chk("pt3_addr", 32'(pt_addr3), 32'(e3[15:8]));
                    chk("pt3_data", 32'(pt_wd3), 32'(e3[7:0]));
                end
            end
            if (!rdy3) begin
                busy3 = 1; run3++; last3 = done3;
                if (done3) dn3++;
            end else begin
                if (done3) chk("done3_idle", 32'(done3), 32'd0);
                if (busy3) begin
                    chk("done3_count", 32'(dn3), 32'd1);
                    chk("done3_last", 32'(last3), 32'd1);
                    if (len3_q.size() == 0) chk("run3_unexpected", 32'(len3_q.size()), 32'd1);
                    else chk("run3_len", 32'(run3), 32'(len3_q.pop_front()));
                    busy3 = 0; run3 = 0; dn3 = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            busy4 = 0; run4 = 0; dn4 = 0; last4 = 0;
        end else begin
            if (pt_we4) begin
                if (exp4_q.size() == 0) chk("pt4_unexpected", 32'(exp4_q.size()), 32'd1);
                else begin
                    e4 = exp4_q.pop_front();
                    chk("pt4_addr", 32'(pt_addr4), 32'(e4[15:8]));
                    chk("pt4_data", 32'(pt_wd4), 32'(e4[7:0]));
                end
            end
            if (!rdy4) begin
                busy4 = 1; run4++; last4 = done4;
                if (done4) dn4++;
            end else begin
                if (done4) chk("done4_idle", 32'(done4), 32'd0);
                if (busy4) begin
                    chk("done4_count", 32'(dn4), 32'd1);
                    chk("done4_last", 32'(last4), 32'd1);
                    if (len4_q.size() == 0) chk("run4_unexpected", 32'(len4_q.size()), 32'd1);
                    else chk("run4_len", 32'(run4), 32'(len4_q.pop_front()));
                    busy4 = 0; run4 = 0; dn4 = 0;
                end
            end
        end
    end

    task automatic load_ct1(input int unit);
        for (int n = 0; n < 10; n++) if (unit == 3) ctm3[n] = CT1[n]; else ctm4[n] = CT1[n];
    endtask

    // Test-1 vector on unit 3: spec plaintext when no drop, reference model otherwise.
    task automatic expect_t1_3();
        if (DROP3 == 0) begin
            for (int n = 0; n < 10; n++) exp3_q.push_back({8'(n), PT1[n]});
            len3_q.push_back(1337);
        end else model_push(3, {232'd0, 24'h4B6579}, 3, DROP3);
    endtask

    task automatic pulse3(input logic [23:0] k);
        @(posedge clk); #1;
        key3 = k; en3 = 1'b1;
        @(posedge clk); #1;
        en3 = 1'b0;
    endtask

    task automatic wait_idle(input int unit, input string tag);
        bit ok;
        ok = 0;
        for (int c = 0; c < 6000; c++) begin
            @(negedge clk);
            if ((unit == 3) ? rdy3 : rdy4) begin ok = 1; break; end
        end
        chk(tag, 32'(ok), 32'd1);
    endtask

    initial begin
        rst = 1'b1; en3 = 1'b0; en4 = 1'b0; key3 = '0; key4 = '0;
        for (int n = 0; n < 256; n++) begin ctm3[n] = 8'd0; ctm4[n] = 8'd0; end
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rdy", 32'(rdy3), 32'd1);
        chk("rst_done", 32'(done3), 32'd0);
        chk("rst_pt_wren", 32'(pt_we3), 32'd0);
        chk("rst_ct_addr", 32'(ct_addr3), 32'd0);
        chk("rst_pt_addr", 32'(pt_addr3), 32'd0);
        chk("rst_pt_wrdata", 32'(pt_wd3), 32'd0);
        chk("rst_rdy4", 32'(rdy4), 32'd1);
        @(posedge clk); #1 rst = 1'b0;

        // Test 1: "Key" / "Plaintext"
        load_ct1(3);
        expect_t1_3();
        pulse3(24'h4B6579);
        wait_idle(3, "t1_timeout");
        chk("t1_all_written", 32'(exp3_q.size()), 32'd0);

        // Test 3: L=0 writes only pt[0]=0
        ctm3[0] = 8'd0;
        exp3_q.push_back(16'h0000);
        len3_q.push_back(1283 + 5*DROP3);
        pulse3(24'hA5C3F0);
        wait_idle(3, "t3_timeout");
        chk("t3_all_written", 32'(exp3_q.size()), 32'd0);

        // Test 4: reset mid-run, then rerun test 1
        load_ct1(3);
        pulse3(24'h4B6579);
        repeat (598) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("t4_rdy_after_rst", 32'(rdy3), 32'd1);
        chk("t4_wren_after_rst", 32'(pt_we3), 32'd0);
        expect_t1_3();
        pulse3(24'h4B6579);
        wait_idle(3, "t4_timeout");
        chk("t4_all_written", 32'(exp3_q.size()), 32'd0);

        // Test 2: "Wiki" / "pedia" on the 4-byte-key unit
        for (int n = 0; n < 6; n++) begin ctm4[n] = CT2[n]; exp4_q.push_back({8'(n), PT2[n]}); end
        len4_q.push_back(1313);
        @(posedge clk); #1 key4 = 32'h57696B69; en4 = 1'b1;
        @(posedge clk); #1 en4 = 1'b0;
        wait_idle(4, "t2_timeout");
        chk("t2_all_written", 32'(exp4_q.size()), 32'd0);

        // Test 5: en held high across two runs, key changed mid-run
        for (int n = 0; n < 6; n++) exp4_q.push_back({8'(n), PT2[n]});
        len4_q.push_back(1313);
        @(posedge clk); #1 key4 = 32'h57696B69; en4 = 1'b1;
        repeat (10) @(posedge clk);
        #1 key4 = 32'h4B657921;
        wait_idle(4, "t5a_timeout");
        load_ct1(4);
        model_push(4, {224'd0, 32'h4B657921}, 4, 0);
        @(posedge clk); #1;
        chk("t5_back_to_back", 32'(rdy4), 32'd0);
        en4 = 1'b0;
        wait_idle(4, "t5b_timeout");
        repeat (5) @(negedge clk);
        chk("t5_stays_idle", 32'(rdy4), 32'd1);
        chk("t5_all_written", 32'(exp4_q.size()), 32'd0);

        // L=255: k reaches 255, i wraps
        ctm3[0] = 8'd255;
        for (int n = 1; n < 256; n++) ctm3[n] = 8'($urandom_range(0, 255));
        model_push(3, {232'd0, 24'h13579B}, 3, DROP3);
        pulse3(24'h13579B);
        wait_idle(3, "l255_timeout");
        chk("l255_all_written", 32'(exp3_q.size()), 32'd0);

`ifdef ARC4_DROP_EN
        // Test 6: drop 256 keystream bytes, "Key", L=4
        ctm3[0] = 8'd4;
        for (int n = 1; n < 5; n++) ctm3[n] = 8'($urandom_range(0, 255));
        model_push(3, {232'd0, 24'h4B6579}, 3, 256);
        pulse3(24'h4B6579);
        wait_idle(3, "t6_timeout");
        chk("t6_all_written", 32'(exp3_q.size()), 32'd0);
`endif

        repeat (3) @(negedge clk);
        chk("end_len3_empty", 32'(len3_q.size()), 32'd0);
        chk("end_len4_empty", 32'(len4_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
